// File: rtl/spi_slave.sv
// SPI mode-3 peripheral endpoint with a 4-register bus slave interface and 8-deep byte FIFOs.
// SCK, MOSI and CS are oversampled in the clk_i domain; SCK edges become single-cycle pulses.
module spi_slave #(
   parameter logic [7:0] FILLBYTE = 8'hFF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [3:2]  adr_i,
   input  logic [3:0]  sel_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [31:0] dat_i,
   output logic [31:0] dat_o,
   output logic        ack_o,
   input  logic        spiClk_i,
   input  logic        spiMosi_i,
   input  logic        spiCs_i,
   output logic        spiMiso_o
);

   logic [2:0]  sck_sync_q, sck_sync_d;
   logic [1:0]  mosi_sync_q, mosi_sync_d;
   logic [1:0]  cs_sync_q, cs_sync_d;
   logic        rise_q, rise_d;
   logic        fall_q, fall_d;

   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic [7:0]  fill_q, fill_d;
   logic        underrun_q, underrun_d;
   logic        overrun_q, overrun_d;

   logic [7:0]  tx_mem_q [8];
   logic [7:0]  tx_mem_d [8];
   logic [2:0]  tx_rd_q, tx_rd_d;
   logic [2:0]  tx_wr_q, tx_wr_d;
   logic [3:0]  tx_cnt_q, tx_cnt_d;

   logic [7:0]  rx_mem_q [8];
   logic [7:0]  rx_mem_d [8];
   logic [2:0]  rx_rd_q, rx_rd_d;
   logic [2:0]  rx_wr_q, rx_wr_d;
   logic [3:0]  rx_cnt_q, rx_cnt_d;

   logic        selected;
   logic        bus_wr, bus_rd;
   logic        tx_empty, tx_full, rx_empty, rx_full;
   logic        tx_push, tx_pop, rx_push, rx_pop;
   logic        byte_start, byte_done;
   logic [7:0]  rx_byte;
   logic [31:0] status;
   logic        unused_bits;

   assign unused_bits = ^{sel_i[3:1], dat_i[31:8]};

   assign selected   = ~cs_sync_q[1];
   assign bus_wr     = stb_i & we_i;
   assign bus_rd     = stb_i & ~we_i;
   assign tx_empty   = (tx_cnt_q == 4'd0);
   assign tx_full    = tx_cnt_q[3];
   assign rx_empty   = (rx_cnt_q == 4'd0);
   assign rx_full    = rx_cnt_q[3];

   assign byte_start = selected & fall_q & (bit_cnt_q == 3'd0);
   assign byte_done  = selected & rise_q & (bit_cnt_q == 3'd7);
   assign rx_byte    = {rx_shift_q[6:0], mosi_sync_q[1]};

   assign tx_push    = bus_wr & (adr_i == 2'd0) & sel_i[0] & ~tx_full;
   assign tx_pop     = byte_start & ~tx_empty;
   assign rx_push    = byte_done & ~rx_full;
   assign rx_pop     = bus_rd & (adr_i == 2'd0) & ~rx_empty;

   assign status = {4'b0, tx_cnt_q, 4'b0, rx_cnt_q, 8'b0,
                    underrun_q, overrun_q, selected, tx_full,
                    rx_cnt_q[3], rx_cnt_q[2], |rx_cnt_q, rx_empty};

   assign ack_o     = stb_i;
   assign spiMiso_o = selected ? tx_shift_q[7] : 1'b1;

   // Pin sampling; the third SCK stage exists only to detect edges.
   always_comb begin
      sck_sync_d  = {sck_sync_q[1:0], spiClk_i};
      mosi_sync_d = {mosi_sync_q[0], spiMosi_i};
      cs_sync_d   = {cs_sync_q[0], spiCs_i};
      rise_d      = sck_sync_q[1] & ~sck_sync_q[2];
      fall_d      = ~sck_sync_q[1] & sck_sync_q[2];
   end

   always_comb begin
      tx_mem_d = tx_mem_q;
      tx_wr_d  = tx_wr_q;
      tx_rd_d  = tx_rd_q;
      if (tx_push) begin
         tx_mem_d[tx_wr_q] = dat_i[7:0];
         tx_wr_d           = tx_wr_q + 3'd1;
      end
      if (tx_pop)
         tx_rd_d = tx_rd_q + 3'd1;
      tx_cnt_d = tx_cnt_q + {3'b0, tx_push} - {3'b0, tx_pop};

      rx_mem_d = rx_mem_q;
      rx_wr_d  = rx_wr_q;
      rx_rd_d  = rx_rd_q;
      if (rx_push) begin
         rx_mem_d[rx_wr_q] = rx_byte;
         rx_wr_d           = rx_wr_q + 3'd1;
      end
      if (rx_pop)
         rx_rd_d = rx_rd_q + 3'd1;
      rx_cnt_d = rx_cnt_q + {3'b0, rx_push} - {3'b0, rx_pop};
   end

   // Shift engine; a deselect mid-byte silently drops the partial byte.
   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      if (!selected) begin
         bit_cnt_d  = 3'd0;
         rx_shift_d = 8'd0;
      end else if (fall_q) begin
         if (bit_cnt_q == 3'd0)
            tx_shift_d = tx_empty ? fill_q : tx_mem_q[tx_rd_q];
         else
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end else if (rise_q) begin
         rx_shift_d = rx_byte;
         bit_cnt_d  = bit_cnt_q + 3'd1;
      end
   end

   // Sticky flags: the bus clear is applied first so a same-cycle set wins.
   always_comb begin
      fill_d     = fill_q;
      underrun_d = underrun_q;
      overrun_d  = overrun_q;
      if (bus_wr && sel_i[0] && adr_i == 2'd2)
         fill_d = dat_i[7:0];
      if (bus_wr && sel_i[0] && adr_i == 2'd1) begin
         if (dat_i[7])
            underrun_d = 1'b0;
         if (dat_i[6])
            overrun_d = 1'b0;
      end
      if (byte_start && tx_empty)
         underrun_d = 1'b1;
      if (byte_done && rx_full)
         overrun_d = 1'b1;
   end

   always_comb begin
      dat_o = 32'd0;
      if (bus_rd) begin
         case (adr_i)
            2'd0:    dat_o = rx_empty ? 32'd0 : {24'd0, rx_mem_q[rx_rd_q]};
            2'd1:    dat_o = status;
            2'd2:    dat_o = {24'd0, fill_q};
            default: dat_o = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sck_sync_q  <= 3'b111;
         mosi_sync_q <= 2'b00;
         cs_sync_q   <= 2'b11;
         rise_q      <= 1'b0;
         fall_q      <= 1'b0;
         bit_cnt_q   <= 3'd0;
         tx_shift_q  <= 8'd0;
         rx_shift_q  <= 8'd0;
         fill_q      <= FILLBYTE;
         underrun_q  <= 1'b0;
         overrun_q   <= 1'b0;
         tx_rd_q     <= 3'd0;
         tx_wr_q     <= 3'd0;
         tx_cnt_q    <= 4'd0;
         rx_rd_q     <= 3'd0;
         rx_wr_q     <= 3'd0;
         rx_cnt_q    <= 4'd0;
         for (int i = 0; i < 8; i++) begin
            tx_mem_q[i] <= 8'd0;
            rx_mem_q[i] <= 8'd0;
         end
      end else begin
         sck_sync_q  <= sck_sync_d;
         mosi_sync_q <= mosi_sync_d;
         cs_sync_q   <= cs_sync_d;
         rise_q      <= rise_d;
         fall_q      <= fall_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_shift_q  <= tx_shift_d;
         rx_shift_q  <= rx_shift_d;
         fill_q      <= fill_d;
         underrun_q  <= underrun_d;
         overrun_q   <= overrun_d;
         tx_rd_q     <= tx_rd_d;
         tx_wr_q     <= tx_wr_d;
         tx_cnt_q    <= tx_cnt_d;
         rx_rd_q     <= rx_rd_d;
         rx_wr_q     <= rx_wr_d;
         rx_cnt_q    <= rx_cnt_d;
         tx_mem_q    <= tx_mem_d;
         rx_mem_q    <= rx_mem_d;
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-3 SPI master model with half-period 6 clk cycles
// drives the pins while bus tasks load/unload the FIFOs; expected values are hand-computed.
module tb_spi_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:2]  adr;
   logic [3:0]  sel;
   logic        stb;
   logic        we;
   logic [31:0] datIn;
   logic [31:0] datOut;
   logic        ack;
   logic        spiClk;
   logic        spiMosi;
   logic        spiCs;
   logic        spiMiso;

   int checkCount = 0;
   int failCount  = 0;

   logic [31:0] rdData;
   logic [7:0]  misoByte;

   always #5 clk = ~clk;

   spi_slave #(.FILLBYTE(8'hFF)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .adr_i     (adr),
      .sel_i     (sel),
      .stb_i     (stb),
      .we_i      (we),
      .dat_i     (datIn),
      .dat_o     (datOut),
      .ack_o     (ack),
      .spiClk_i  (spiClk),
      .spiMosi_i (spiMosi),
      .spiCs_i   (spiCs),
      .spiMiso_o (spiMiso)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      adr   = a;
      sel   = 4'h1;
      we    = 1'b1;
      datIn = d;
      stb   = 1'b1;
      @(posedge clk);
      #1;
      stb = 1'b0;
      we  = 1'b0;
   endtask

   task automatic busRead(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      adr = a;
      sel = 4'hF;
      we  = 1'b0;
      stb = 1'b1;
      #2;
      d = datOut;
      checkOutput("ack", {31'd0, ack}, 32'd1);
      @(posedge clk);
      #1;
      stb = 1'b0;
   endtask

   // Mode-3 master: MOSI changes on the falling edge, MISO is sampled just before the rising edge.
   task automatic applyStimulus(input logic [7:0] mosiByte, input int nBits, output logic [7:0] misoOut);
      misoOut = 8'd0;
      for (int i = 0; i < nBits; i++) begin
         @(posedge clk);
         #1;
         spiClk  = 1'b0;
         spiMosi = mosiByte[7-i];
         repeat (6) @(posedge clk);
         #1;
         misoOut = {misoOut[6:0], spiMiso};
         spiClk  = 1'b1;
         repeat (5) @(posedge clk);
      end
   endtask

   task automatic chipSelect(input logic level);
      @(posedge clk);
      #1;
      spiCs = level;
      repeat (6) @(posedge clk);
   endtask

   initial begin
      #500000;
      failCount++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

   initial begin
      rst     = 1'b1;
      adr     = 2'd0;
      sel     = 4'h0;
      stb     = 1'b0;
      we      = 1'b0;
      datIn   = 32'd0;
      spiClk  = 1'b1;
      spiMosi = 1'b0;
      spiCs   = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state
      checkOutput("resetMiso", {31'd0, spiMiso}, 32'd1);
      busRead(2'd1, rdData);
      checkOutput("resetStatus", rdData, 32'h0000_0001);
      busRead(2'd2, rdData);
      checkOutput("resetFill", rdData, 32'h0000_00FF);
      busRead(2'd3, rdData);
      checkOutput("reg3Read", rdData, 32'd0);

      // Single byte exchange
      busWrite(2'd0, 32'h0000_00A5);
      busRead(2'd1, rdData);
      checkOutput("txQueued", rdData, 32'h0100_0001);
      chipSelect(1'b0);
      applyStimulus(8'h3C, 8, misoByte);
      checkOutput("singleMiso", {24'd0, misoByte}, 32'h0000_00A5);
      busRead(2'd1, rdData);
      checkOutput("singleStatus", rdData, 32'h0001_0022);
      chipSelect(1'b1);
      busRead(2'd0, rdData);
      checkOutput("singleRx", rdData, 32'h0000_003C);
      busRead(2'd1, rdData);
      checkOutput("singleEmpty", rdData, 32'h0000_0001);

      // Underrun with a programmed fill byte
      busWrite(2'd2, 32'h0000_005A);
      busRead(2'd2, rdData);
      checkOutput("fillReg", rdData, 32'h0000_005A);
      chipSelect(1'b0);
      applyStimulus(8'h00, 8, misoByte);
      checkOutput("underrunMiso", {24'd0, misoByte}, 32'h0000_005A);
      chipSelect(1'b1);
      busRead(2'd0, rdData);
      checkOutput("underrunRx", rdData, 32'h0000_0000);
      busRead(2'd1, rdData);
      checkOutput("underrunFlag", rdData, 32'h0000_0081);
      busWrite(2'd1, 32'h0000_0080);
      busRead(2'd1, rdData);
      checkOutput("underrunClear", rdData, 32'h0000_0001);

      // Overrun: nine bytes into an eight-deep FIFO
      chipSelect(1'b0);
      for (int b = 1; b <= 9; b++)
         applyStimulus(8'(b), 8, misoByte);
      chipSelect(1'b1);
      busRead(2'd1, rdData);
      checkOutput("overrunStatus", rdData, 32'h0008_00CA);
      for (int b = 1; b <= 8; b++) begin
         busRead(2'd0, rdData);
         checkOutput($sformatf("overrunRx%0d", b), rdData, 32'(b));
      end
      busRead(2'd0, rdData);
      checkOutput("emptyRead", rdData, 32'd0);
      busWrite(2'd1, 32'h0000_00C0);
      busRead(2'd1, rdData);
      checkOutput("flagsClear", rdData, 32'h0000_0001);

      // Chip select abort after four bits
      chipSelect(1'b0);
      applyStimulus(8'hF0, 4, misoByte);
      repeat (6) @(posedge clk);
      chipSelect(1'b1);
      chipSelect(1'b0);
      applyStimulus(8'h81, 8, misoByte);
      checkOutput("abortMiso", {24'd0, misoByte}, 32'h0000_005A);
      chipSelect(1'b1);
      busRead(2'd1, rdData);
      checkOutput("abortStatus", rdData, 32'h0001_0082);
      busRead(2'd0, rdData);
      checkOutput("abortRx", rdData, 32'h0000_0081);
      busWrite(2'd1, 32'h0000_0080);

      // Streaming three back-to-back bytes
      busWrite(2'd0, 32'h0000_0011);
      busWrite(2'd0, 32'h0000_0022);
      busWrite(2'd0, 32'h0000_0033);
      busRead(2'd1, rdData);
      checkOutput("streamQueued", rdData, 32'h0300_0001);
      chipSelect(1'b0);
      applyStimulus(8'hC1, 8, misoByte);
      checkOutput("streamMiso0", {24'd0, misoByte}, 32'h0000_0011);
      applyStimulus(8'hC2, 8, misoByte);
      checkOutput("streamMiso1", {24'd0, misoByte}, 32'h0000_0022);
      applyStimulus(8'hC3, 8, misoByte);
      checkOutput("streamMiso2", {24'd0, misoByte}, 32'h0000_0033);
      chipSelect(1'b1);
      busRead(2'd1, rdData);
      checkOutput("streamStatus", rdData, 32'h0003_0002);
      busRead(2'd0, rdData);
      checkOutput("streamRx0", rdData, 32'h0000_00C1);
      busRead(2'd0, rdData);
      checkOutput("streamRx1", rdData, 32'h0000_00C2);
      busRead(2'd0, rdData);
      checkOutput("streamRx2", rdData, 32'h0000_00C3);

      // Reset in the middle of a transfer
      busWrite(2'd0, 32'h0000_0077);
      busWrite(2'd2, 32'h0000_0012);
      chipSelect(1'b0);
      applyStimulus(8'hE7, 5, misoByte);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rstMiso", {31'd0, spiMiso}, 32'd1);
      busRead(2'd1, rdData);
      checkOutput("rstStatus", rdData, 32'h0000_0001);
      busRead(2'd2, rdData);
      checkOutput("rstFill", rdData, 32'h0000_00FF);
      @(negedge clk);
      rst   = 1'b0;
      spiCs = 1'b1;
      repeat (6) @(posedge clk);
      busRead(2'd1, rdData);
      checkOutput("postRstStatus", rdData, 32'h0000_0001);
      busRead(2'd0, rdData);
      checkOutput("postRstRx", rdData, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
